// File: rtl/cmul_tb_pkg.sv
// Shared state encoding and LFSR constants for the complex-multiplier stimulus driver.
package cmul_tb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_PULSE,
    S_DRIVE,
    S_WAIT_RES,
    S_GAP,
    S_DONE
  } drv_state_t;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1, right-shifting form
  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_5EED;

endpackage

// File: rtl/lfsr_operand_gen.sv
// 32-bit Galois LFSR operand source; each operand is the low slice of the state
// rotated right by 0, 8, 16 or 24 bits.
module lfsr_operand_gen
  import cmul_tb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [31:0] SEED       = DEFAULT_SEED
) (
  input  logic                  clk,
  input  logic                  load,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] op_1_re,
  output logic [DATA_WIDTH-1:0] op_1_im,
  output logic [DATA_WIDTH-1:0] op_2_re,
  output logic [DATA_WIDTH-1:0] op_2_im
);

  logic [31:0] state;

  function automatic logic [DATA_WIDTH-1:0] view(input logic [31:0] v, input int unsigned rot);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r[i] = v[5'((i + rot) % 32)];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (load) begin
      state <= SEED;
    end else if (advance) begin
      state <= state[0] ? ((state >> 1) ^ LFSR_POLY) : (state >> 1);
    end
  end

  assign op_1_re = view(state, 0);
  assign op_1_im = view(state, 8);
  assign op_2_re = view(state, 16);
  assign op_2_im = view(state, 24);

endmodule

// File: rtl/driver_complex_multiplier.sv
// Stimulus driver for the complex multiplier: LFSR operands over op_val/op_ready,
// results accepted over res_val/res_ready, a fixed number of transactions per start.
//   state      | meaning
//   IDLE       | after reset, waiting for start
//   RST_PULSE  | sw_rst high for one cycle, txn_count already cleared
//   DRIVE      | op_val high, operands held until op_ready
//   WAIT_RES   | res_ready high until res_val
//   GAP        | idle spacing before the next operand set
//   DONE       | run complete, done high until the next start
module driver_complex_multiplier
  import cmul_tb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter logic [15:0] NR_TRANSACTIONS = 16'd16,
  parameter int unsigned GAP_CYCLES      = 2,
  parameter logic [31:0] LFSR_SEED       = DEFAULT_SEED
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  output logic                    sw_rst,
  output logic                    op_val,
  output logic [DATA_WIDTH-1:0]   op_1_re,
  output logic [DATA_WIDTH-1:0]   op_1_im,
  output logic [DATA_WIDTH-1:0]   op_2_re,
  output logic [DATA_WIDTH-1:0]   op_2_im,
  input  logic                    op_ready,
  input  logic                    res_val,
  output logic                    res_ready,
  input  logic [2*DATA_WIDTH-1:0] result_re,
  input  logic [2*DATA_WIDTH-1:0] result_im,
  output logic [2*DATA_WIDTH-1:0] last_result_re,
  output logic [2*DATA_WIDTH-1:0] last_result_im,
  output logic [15:0]             txn_count,
  output logic                    done
);

  localparam logic [15:0] GAP_LOAD = (GAP_CYCLES != 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  drv_state_t            state, state_nxt;
  logic [15:0]           gap_cnt;
  logic                  xfer, accept, run_start, last_txn;
  logic [DATA_WIDTH-1:0] gen_1_re, gen_1_im, gen_2_re, gen_2_im;

  assign xfer      = (state == S_DRIVE) && op_ready;
  assign accept    = (state == S_WAIT_RES) && res_val;
  assign run_start = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_txn  = ({1'b0, txn_count} + 17'd1) == {1'b0, NR_TRANSACTIONS};

  // Reset reseeds the LFSR; a new start does not, so consecutive runs continue the sequence
  lfsr_operand_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .SEED      (LFSR_SEED)
  ) u_gen (
    .clk    (clk),
    .load   (~rstn),
    .advance(xfer),
    .op_1_re(gen_1_re),
    .op_1_im(gen_1_im),
    .op_2_re(gen_2_re),
    .op_2_im(gen_2_im)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sw_rst    = 1'b0;
    op_val    = 1'b0;
    res_ready = 1'b0;
    done      = 1'b0;
    op_1_re   = '0;
    op_1_im   = '0;
    op_2_re   = '0;
    op_2_im   = '0;
    unique case (state)
      S_IDLE: begin
        if (run_start) state_nxt = S_RST_PULSE;
      end
      S_RST_PULSE: begin
        sw_rst    = 1'b1;
        state_nxt = (NR_TRANSACTIONS == 16'd0) ? S_DONE : S_DRIVE;
      end
      S_DRIVE: begin
        op_val  = 1'b1;
        op_1_re = gen_1_re;
        op_1_im = gen_1_im;
        op_2_re = gen_2_re;
        op_2_im = gen_2_im;
        if (op_ready) state_nxt = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        res_ready = 1'b1;
        if (res_val) begin
          if (last_txn)             state_nxt = S_DONE;
          else if (GAP_CYCLES != 0) state_nxt = S_GAP;
          else                      state_nxt = S_DRIVE;
        end
      end
      S_GAP: begin
        if (gap_cnt == 16'd0) state_nxt = S_DRIVE;
      end
      S_DONE: begin
        done = 1'b1;
        if (run_start) state_nxt = S_RST_PULSE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      txn_count      <= '0;
      last_result_re <= '0;
      last_result_im <= '0;
      gap_cnt        <= '0;
    end else begin
      if (run_start) begin
        txn_count <= '0;
      end else if (accept) begin
        last_result_re <= result_re;
        last_result_im <= result_im;
        if (txn_count != 16'hFFFF) txn_count <= txn_count + 16'd1;
      end
      if (accept) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == S_GAP) && (gap_cnt != 16'd0)) begin
        gap_cnt <= gap_cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_driver_complex_multiplier.sv
// Self-checking bench for driver_complex_multiplier: a table for the zero-wait run, hand
// sequences for reset/backpressure/late result/start-in-gap, and a randomized responder.
module tb_driver_complex_multiplier;

  localparam int          W     = 8;
  localparam logic [31:0] SEED  = 32'hACE1_5EED;
  localparam int          NR_B  = 6;
  localparam int          GAP_B = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic           a_start, a_sw_rst, a_op_val, a_op_ready, a_res_val, a_res_ready, a_done;
  logic [W-1:0]   a_op_1_re, a_op_1_im, a_op_2_re, a_op_2_im;
  logic [2*W-1:0] a_result_re, a_result_im, a_last_re, a_last_im;
  logic [15:0]    a_txn;

  logic           b_start, b_sw_rst, b_op_val, b_op_ready, b_res_val, b_res_ready, b_done;
  logic [W-1:0]   b_op_1_re, b_op_1_im, b_op_2_re, b_op_2_im;
  logic [2*W-1:0] b_result_re, b_result_im, b_last_re, b_last_im;
  logic [15:0]    b_txn;

  logic           c_start, c_sw_rst, c_op_val, c_op_ready, c_res_val, c_res_ready, c_done;
  logic [W-1:0]   c_op_1_re, c_op_1_im, c_op_2_re, c_op_2_im;
  logic [2*W-1:0] c_result_re, c_result_im, c_last_re, c_last_im;
  logic [15:0]    c_txn;

  driver_complex_multiplier #(.DATA_WIDTH(W), .NR_TRANSACTIONS(16'd4), .GAP_CYCLES(0),
                              .LFSR_SEED(SEED)) dut_a (
    .clk(clk), .rstn(rstn), .start(a_start), .sw_rst(a_sw_rst), .op_val(a_op_val),
    .op_1_re(a_op_1_re), .op_1_im(a_op_1_im), .op_2_re(a_op_2_re), .op_2_im(a_op_2_im),
    .op_ready(a_op_ready), .res_val(a_res_val), .res_ready(a_res_ready),
    .result_re(a_result_re), .result_im(a_result_im),
    .last_result_re(a_last_re), .last_result_im(a_last_im), .txn_count(a_txn), .done(a_done));

  driver_complex_multiplier #(.DATA_WIDTH(W), .NR_TRANSACTIONS(16'(NR_B)), .GAP_CYCLES(GAP_B),
                              .LFSR_SEED(SEED)) dut_b (
    .clk(clk), .rstn(rstn), .start(b_start), .sw_rst(b_sw_rst), .op_val(b_op_val),
    .op_1_re(b_op_1_re), .op_1_im(b_op_1_im), .op_2_re(b_op_2_re), .op_2_im(b_op_2_im),
    .op_ready(b_op_ready), .res_val(b_res_val), .res_ready(b_res_ready),
    .result_re(b_result_re), .result_im(b_result_im),
    .last_result_re(b_last_re), .last_result_im(b_last_im), .txn_count(b_txn), .done(b_done));

  driver_complex_multiplier #(.DATA_WIDTH(W), .NR_TRANSACTIONS(16'd0), .GAP_CYCLES(GAP_B),
                              .LFSR_SEED(SEED)) dut_c (
    .clk(clk), .rstn(rstn), .start(c_start), .sw_rst(c_sw_rst), .op_val(c_op_val),
    .op_1_re(c_op_1_re), .op_1_im(c_op_1_im), .op_2_re(c_op_2_re), .op_2_im(c_op_2_im),
    .op_ready(c_op_ready), .res_val(c_res_val), .res_ready(c_res_ready),
    .result_re(c_result_re), .result_im(c_result_im),
    .last_result_re(c_last_re), .last_result_im(c_last_im), .txn_count(c_txn), .done(c_done));

  typedef struct {
    logic        start;
    logic        e_sw;
    logic        e_ov;
    logic        e_rr;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] ma_lfsr, mb_lfsr, exp_a_last, exp_b_last;
  int          exp_txn;
  bit          reached;
  vec_t        tbl[14];

  // For W=8 the four rotated slices, packed {im2, re2, im1, re1}, are the LFSR state itself.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic vec_t mk(input logic s, input logic sw, input logic ov, input logic rr,
                              input logic dn, input logic [15:0] c);
    vec_t v;
    v.start = s; v.e_sw = sw; v.e_ov = ov; v.e_rr = rr; v.e_done = dn; v.e_cnt = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_b_zero(input string tag);
    check({tag, "_sw_rst"}, b_sw_rst, 0);
    check({tag, "_op_val"}, b_op_val, 0);
    check({tag, "_ops"}, {b_op_2_im, b_op_2_re, b_op_1_im, b_op_1_re}, 0);
    check({tag, "_res_ready"}, b_res_ready, 0);
    check({tag, "_last"}, {b_last_re, b_last_im}, 0);
    check({tag, "_txn"}, b_txn, 0);
    check({tag, "_done"}, b_done, 0);
  endtask

  // Random responder for dut_b; entered with the DUT presenting operands.
  task automatic run_random(input bit stop_mid, output bit got_there);
    int   since_acc;
    bit   awaiting;
    logic xfr, acc;
    got_there = 0;
    since_acc = GAP_B;
    awaiting  = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      check("rnd_done", b_done, exp_txn == NR_B);
      check("rnd_txn", b_txn, exp_txn);
      if (exp_txn == NR_B) begin
        got_there = 1;
        return;
      end
      if (stop_mid && awaiting && exp_txn == 3) begin
        got_there = 1;
        return;
      end
      check("rnd_res_ready", b_res_ready, awaiting);
      check("rnd_op_val", b_op_val, !awaiting && since_acc >= GAP_B);
      if (b_op_val) check("rnd_ops", {b_op_2_im, b_op_2_re, b_op_1_im, b_op_1_re}, mb_lfsr);
      b_op_ready  = ($urandom_range(0, 2) != 0);
      b_res_val   = ($urandom_range(0, 2) == 0);
      b_result_re = 16'($urandom);
      b_result_im = 16'($urandom);
      xfr = !awaiting && (since_acc >= GAP_B) && b_op_ready;
      acc = awaiting && b_res_val;
      tick();
      since_acc++;
      if (xfr) begin
        mb_lfsr  = lfsr_step(mb_lfsr);
        awaiting = 1;
      end
      if (acc) begin
        awaiting   = 0;
        since_acc  = 0;
        exp_txn++;
        exp_b_last = {b_result_re, b_result_im};
        check("rnd_last", {b_last_re, b_last_im}, exp_b_last);
      end
    end
    n_checks++;
    $display("FAIL rnd_timeout: got no completion, expected txn %0d (stop_mid=%0d)", NR_B, stop_mid);
  endtask

  initial begin
    a_start = 0; a_op_ready = 1; a_res_val = 1; a_result_re = '0; a_result_im = '0;
    b_start = 1; b_op_ready = 0; b_res_val = 0; b_result_re = '0; b_result_im = '0;
    c_start = 0; c_op_ready = 0; c_res_val = 0; c_result_re = '0; c_result_im = '0;

    tbl[0]  = mk(1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 1, 0, 1);
    tbl[6]  = mk(0, 0, 1, 0, 0, 2);
    tbl[7]  = mk(0, 0, 0, 1, 0, 2);
    tbl[8]  = mk(0, 0, 1, 0, 0, 3);
    tbl[9]  = mk(0, 0, 0, 1, 0, 3);
    tbl[10] = mk(0, 0, 0, 0, 1, 4);
    tbl[11] = mk(1, 0, 0, 0, 1, 4);
    tbl[12] = mk(0, 1, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 1, 0, 0, 0);

    // Reset held 3 cycles with start asserted: reset wins
    repeat (3) tick();
    check_b_zero("rst");
    check("rst_a_done", a_done, 0);
    check("rst_c_sw_rst", c_sw_rst, 0);
    rstn = 1; b_start = 0;
    tick();
    check("rst_start_overridden", b_sw_rst, 0);

    // Zero-wait run on dut_a
    ma_lfsr    = SEED;
    exp_a_last = '0;
    for (int i = 0; i < 14; i++) begin
      logic xfr, acc;
      a_start     = tbl[i].start;
      a_result_re = 16'h0100 + 16'(i);
      a_result_im = 16'h0F00 - 16'(i);
      check($sformatf("tbl%0d_sw_rst", i), a_sw_rst, tbl[i].e_sw);
      check($sformatf("tbl%0d_op_val", i), a_op_val, tbl[i].e_ov);
      check($sformatf("tbl%0d_res_ready", i), a_res_ready, tbl[i].e_rr);
      check($sformatf("tbl%0d_done", i), a_done, tbl[i].e_done);
      check($sformatf("tbl%0d_txn", i), a_txn, tbl[i].e_cnt);
      check($sformatf("tbl%0d_last", i), {a_last_re, a_last_im}, exp_a_last);
      if (tbl[i].e_ov)
        check($sformatf("tbl%0d_ops", i), {a_op_2_im, a_op_2_re, a_op_1_im, a_op_1_re}, ma_lfsr);
      xfr = tbl[i].e_ov;
      acc = tbl[i].e_rr;
      tick();
      if (xfr) ma_lfsr = lfsr_step(ma_lfsr);
      if (acc) exp_a_last = {a_result_re, a_result_im};
    end
    a_start = 0;

    // Zero-transaction run: done two cycles after start
    c_start = 1;
    tick();
    c_start = 0;
    check("c_sw_rst", c_sw_rst, 1);
    check("c_done_early", c_done, 0);
    tick();
    check("c_done", c_done, 1);
    check("c_sw_rst_off", c_sw_rst, 0);
    check("c_op_val", c_op_val, 0);

    // Backpressure: operands held for 5 stalled cycles, transfer on the 6th
    mb_lfsr = SEED;
    b_start = 1;
    tick();
    b_start = 0;
    check("bp_sw_rst", b_sw_rst, 1);
    check("bp_op_val_rst", b_op_val, 0);
    tick();
    check("bp_sw_rst_once", b_sw_rst, 0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_op_val_%0d", k), b_op_val, 1);
      check($sformatf("bp_ops_%0d", k), {b_op_2_im, b_op_2_re, b_op_1_im, b_op_1_re}, mb_lfsr);
      check($sformatf("bp_res_ready_%0d", k), b_res_ready, 0);
      tick();
    end
    check("bp_op_val_6", b_op_val, 1);
    check("bp_ops_6", {b_op_2_im, b_op_2_re, b_op_1_im, b_op_1_re}, mb_lfsr);
    b_op_ready = 1;
    tick();
    b_op_ready = 0;
    mb_lfsr = lfsr_step(mb_lfsr);
    check("bp_xfer_op_val", b_op_val, 0);

    // Late result: 7 cycles of waiting, then accept
    for (int k = 0; k < 7; k++) begin
      check($sformatf("late_res_ready_%0d", k), b_res_ready, 1);
      check($sformatf("late_txn_%0d", k), b_txn, 0);
      tick();
    end
    b_res_val = 1; b_result_re = 16'h1234; b_result_im = 16'hFEDC;
    check("late_res_ready_7", b_res_ready, 1);
    tick();
    check("late_last", {b_last_re, b_last_im}, 32'h1234_FEDC);
    check("late_txn", b_txn, 1);
    check("late_gap_res_ready", b_res_ready, 0);

    // In GAP: res_val and start are both ignored
    b_result_re = 16'h5555; b_result_im = 16'hAAAA;
    b_start = 1;
    tick();
    b_start = 0; b_res_val = 0;
    check("gap_sw_rst", b_sw_rst, 0);
    check("gap_txn", b_txn, 1);
    check("gap_last", {b_last_re, b_last_im}, 32'h1234_FEDC);
    check("gap_op_val", b_op_val, 0);
    tick();
    check("gap_end_op_val", b_op_val, 1);
    check("gap_end_ops", {b_op_2_im, b_op_2_re, b_op_1_im, b_op_1_re}, mb_lfsr);

    // Rest of run 1, then a second full run continuing the LFSR sequence
    exp_txn    = 1;
    exp_b_last = 32'h1234_FEDC;
    run_random(0, reached);
    b_op_ready = 0; b_res_val = 0;
    b_start = 1;
    tick();
    b_start = 0;
    check("run2_sw_rst", b_sw_rst, 1);
    check("run2_txn_clear", b_txn, 0);
    check("run2_done_clear", b_done, 0);
    tick();
    exp_txn = 0;
    run_random(0, reached);

    // Third run, reset in WAIT_RES with three transactions done
    b_op_ready = 0; b_res_val = 0;
    b_start = 1;
    tick();
    b_start = 0;
    tick();
    exp_txn = 0;
    run_random(1, reached);
    if (reached) begin
      check("mid_txn_before", b_txn, 3);
      check("mid_res_ready_before", b_res_ready, 1);
      rstn = 0; b_res_val = 1; b_op_ready = 0;
      tick();
      check_b_zero("mid");
      rstn = 1; b_res_val = 0;
      mb_lfsr = SEED;
      b_start = 1;
      tick();
      b_start = 0;
      check("mid_sw_rst", b_sw_rst, 1);
      tick();
      check("mid_op_val", b_op_val, 1);
      check("mid_ops_seed", {b_op_2_im, b_op_2_re, b_op_1_im, b_op_1_re}, mb_lfsr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
